// File: rtl/cpu_pkg.sv
// Shared definitions for the core control path.
//   seq_state_t    : instruction sequencer state encoding (also exported on
//                    the sequencer's debug state port).
//   MEM_BYTE/HALF/WORD : mem_size encodings; 3 is reserved and handled as word.
//   is_misaligned  : alignment check of an effective address for a given size.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    EXECUTE    = 3'd2,
    MEM_ADDR   = 3'd3,
    MEM_ACCESS = 3'd4,
    WRITEBACK  = 3'd5,
    HALTED     = 3'd6,
    FAULT      = 3'd7
  } seq_state_t;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // Bytes are always aligned; halves need bit 0 clear; words (and the
  // reserved size, treated as word) need both low bits clear.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_low);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_low[0];
      default:  return (addr_low != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/access_timer.sv
// Bounded-wait counter for memory accesses.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the count (takes priority over count)
//   count        : increment the count this cycle
//   expired      : count has reached MEM_TIMEOUT
module access_timer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMER_W     = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [TIMER_W-1:0] timer;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples its inputs from before the edge.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      timer <= '0;
    end else if (count) begin
      timer <= timer + 1'b1;
    end
  end

  // No saturation needed: expiry always moves the sequencer out of the
  // waiting state, which clears the counter on the next edge.
  assign expired = (timer == TIMER_W'(MEM_TIMEOUT));

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, data address, data access
// and writeback, with a mem_ready handshake and bounded wait.
//   clock, reset        : system clock, synchronous active-high reset
//   mem_ready           : memory completes the current access this cycle
//   is_load/is_store/is_jump/is_halt : decoded instruction class (EXECUTE)
//   mem_size, addr_low  : access size and effective address bits [1:0]
//   pc_write, pc_jump, pc_use_offset, pc_addr_to_ad : program counter controls
//   mem_read, mem_write : memory strobes
//   ir_load, reg_write  : instruction register load, register-file write
//   halted, fault       : sticky status (left only through reset)
//   state               : current state encoding for debug
module instruction_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TIMER_W     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       is_jump,
  input  logic       is_halt,
  input  logic [1:0] mem_size,
  input  logic [1:0] addr_low,
  output logic       pc_write,
  output logic       pc_jump,
  output logic       pc_use_offset,
  output logic       pc_addr_to_ad,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_load,
  output logic       reg_write,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  seq_state_t cur_state, next_state;
  logic       timer_clear, timer_count, timer_expired;

  access_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMER_W     (TIMER_W)
  ) u_access_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    next_state    = cur_state;
    pc_write      = 1'b0;
    pc_jump       = 1'b0;
    pc_use_offset = 1'b0;
    pc_addr_to_ad = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_load       = 1'b0;
    reg_write     = 1'b0;

    case (cur_state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end else if (timer_expired) begin
          next_state = FAULT;
        end
      end
      DECODE: next_state = EXECUTE;
      EXECUTE: begin
        if (is_halt) begin
          next_state = HALTED;
        end else if (is_jump) begin
          pc_jump    = 1'b1;
          reg_write  = 1'b1;
          next_state = FETCH;
        end else if (is_load || is_store) begin
          next_state = MEM_ADDR;
        end else begin
          reg_write  = 1'b1;
          next_state = FETCH;
        end
      end
      MEM_ADDR: begin
        pc_addr_to_ad = 1'b1;
        pc_use_offset = 1'b1;
        next_state    = is_misaligned(mem_size, addr_low) ? FAULT : MEM_ACCESS;
      end
      MEM_ACCESS: begin
        pc_addr_to_ad = 1'b1;
        pc_use_offset = 1'b1;
        // Load wins if the decoder ever flags both, keeping the strobes exclusive.
        mem_read      = is_load;
        mem_write     = is_store && !is_load;
        if (mem_ready) begin
          next_state = is_load ? WRITEBACK : FETCH;
        end else if (timer_expired) begin
          next_state = FAULT;
        end
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      default: next_state = cur_state;  // HALTED and FAULT are absorbing
    endcase

    // Reset overrides everything so no strobe escapes while it is asserted.
    if (reset) begin
      pc_write      = 1'b0;
      pc_jump       = 1'b0;
      pc_use_offset = 1'b0;
      pc_addr_to_ad = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_load       = 1'b0;
      reg_write     = 1'b0;
    end
  end

  // Any state change restarts the wait count, so FETCH and MEM_ACCESS always
  // begin from zero; only a stalled access advances it.
  assign timer_clear = (next_state != cur_state);
  assign timer_count = ((cur_state == FETCH) || (cur_state == MEM_ACCESS)) && !mem_ready;

  assign halted = (cur_state == HALTED);
  assign fault  = (cur_state == FAULT);
  assign state  = cur_state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer. Inputs change just
// after the falling edge; outputs are compared 1 ns later, well away from the
// rising edge. Strobe vector order:
// {pc_write, pc_jump, pc_use_offset, pc_addr_to_ad, mem_read, mem_write, ir_load, reg_write}
module tb_instruction_sequencer;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       mem_ready, is_load, is_store, is_jump, is_halt;
  logic [1:0] mem_size, addr_low;
  logic       pc_write, pc_jump, pc_use_offset, pc_addr_to_ad;
  logic       mem_read, mem_write, ir_load, reg_write, halted, fault;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] S_NONE  = 8'h00;
  localparam logic [7:0] S_FETCH = 8'h8A;  // pc_write, mem_read, ir_load
  localparam logic [7:0] S_WAIT  = 8'h08;  // mem_read only
  localparam logic [7:0] S_REGW  = 8'h01;
  localparam logic [7:0] S_JUMP  = 8'h41;  // pc_jump, reg_write
  localparam logic [7:0] S_ADDR  = 8'h30;  // use_offset, addr_to_ad
  localparam logic [7:0] S_LOAD  = 8'h38;
  localparam logic [7:0] S_STORE = 8'h34;

  instruction_sequencer #(.MEM_TIMEOUT(15), .TIMER_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_ready     (mem_ready),
    .is_load       (is_load),
    .is_store      (is_store),
    .is_jump       (is_jump),
    .is_halt       (is_halt),
    .mem_size      (mem_size),
    .addr_low      (addr_low),
    .pc_write      (pc_write),
    .pc_jump       (pc_jump),
    .pc_use_offset (pc_use_offset),
    .pc_addr_to_ad (pc_addr_to_ad),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_load       (ir_load),
    .reg_write     (reg_write),
    .halted        (halted),
    .fault         (fault),
    .state         (state)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] strobes();
    return {pc_write, pc_jump, pc_use_offset, pc_addr_to_ad,
            mem_read, mem_write, ir_load, reg_write};
  endfunction

  task automatic set_instr(input logic ld, input logic st, input logic jp,
                           input logic ht, input logic [1:0] sz, input logic [1:0] al);
    is_load = ld; is_store = st; is_jump = jp; is_halt = ht;
    mem_size = sz; addr_low = al;
  endtask

  // Leaves the DUT at the start of its first FETCH cycle, just after a falling edge.
  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1;
    set_instr(1'b0, 1'b1, 1'b0, 1'b0, MEM_WORD, 2'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (strobes() !== S_NONE) begin
        bad++;
        $display("FAIL reset_strobes cyc%0d got=%b want=%b", i, strobes(), S_NONE);
      end
      @(negedge clock);
    end
    reset = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, MEM_WORD, 2'd0);
    #1;
    total++;
    if ({state, halted, fault} !== {FETCH, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got state=%0d halted=%b fault=%b want state=0 halted=0 fault=0",
               state, halted, fault);
    end
    @(negedge clock);
  endtask

  task automatic test_alu();
    logic [2:0] es [0:2];
    logic [7:0] eo [0:2];
    es = '{FETCH, DECODE, EXECUTE};
    eo = '{S_FETCH, S_NONE, S_REGW};
    apply_reset();
    mem_ready = 1'b1;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, MEM_WORD, 2'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({state, strobes()} !== {es[i], eo[i]}) begin
        bad++;
        $display("FAIL alu cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, state, strobes(), es[i], eo[i]);
      end
      @(negedge clock);
    end
    #1;
    total++;
    if (state !== FETCH) begin
      bad++;
      $display("FAIL alu_return got state=%0d want state=%0d", state, FETCH);
    end
    @(negedge clock);
  endtask

  task automatic test_jump();
    logic [2:0] es [0:3];
    logic [7:0] eo [0:3];
    es = '{FETCH, DECODE, EXECUTE, FETCH};
    eo = '{S_FETCH, S_NONE, S_JUMP, S_FETCH};
    apply_reset();
    mem_ready = 1'b1;
    set_instr(1'b0, 1'b0, 1'b1, 1'b0, MEM_WORD, 2'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({state, strobes()} !== {es[i], eo[i]}) begin
        bad++;
        $display("FAIL jump cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, state, strobes(), es[i], eo[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_load_wait();
    logic [2:0] es [0:8];
    logic [7:0] eo [0:8];
    logic       rd [0:8];
    es = '{FETCH, DECODE, EXECUTE, MEM_ADDR, MEM_ACCESS, MEM_ACCESS, MEM_ACCESS,
           MEM_ACCESS, WRITEBACK};
    eo = '{S_FETCH, S_NONE, S_NONE, S_ADDR, S_LOAD, S_LOAD, S_LOAD, S_LOAD, S_REGW};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apply_reset();
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, MEM_WORD, 2'd0);
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      #1;
      total++;
      if ({state, strobes()} !== {es[i], eo[i]}) begin
        bad++;
        $display("FAIL load_wait cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, state, strobes(), es[i], eo[i]);
      end
      @(negedge clock);
    end
    #1;
    total++;
    if (state !== FETCH) begin
      bad++;
      $display("FAIL load_return got state=%0d want state=%0d", state, FETCH);
    end
    @(negedge clock);
  endtask

  // Byte store at addr_low=3: bytes are never misaligned; 5-cycle minimum.
  task automatic test_store_byte();
    logic [2:0] es [0:5];
    logic [7:0] eo [0:5];
    es = '{FETCH, DECODE, EXECUTE, MEM_ADDR, MEM_ACCESS, FETCH};
    eo = '{S_FETCH, S_NONE, S_NONE, S_ADDR, S_STORE, S_FETCH};
    apply_reset();
    mem_ready = 1'b1;
    set_instr(1'b0, 1'b1, 1'b0, 1'b0, MEM_BYTE, 2'd3);
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if ({state, strobes()} !== {es[i], eo[i]}) begin
        bad++;
        $display("FAIL store_byte cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, state, strobes(), es[i], eo[i]);
      end
      @(negedge clock);
    end
  endtask

  // Half store at addr_low=1, then a reserved-size (word) load at addr_low=2.
  task automatic test_misaligned();
    logic [2:0] es [0:6];
    logic [7:0] eo [0:6];
    es = '{FETCH, DECODE, EXECUTE, MEM_ADDR, FAULT, FAULT, FAULT};
    eo = '{S_FETCH, S_NONE, S_NONE, S_ADDR, S_NONE, S_NONE, S_NONE};
    for (int j = 0; j < 2; j++) begin
      apply_reset();
      mem_ready = 1'b1;
      if (j == 0) set_instr(1'b0, 1'b1, 1'b0, 1'b0, MEM_HALF, 2'd1);
      else        set_instr(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd2);
      for (int i = 0; i < 7; i++) begin
        #1;
        total++;
        if ({state, strobes()} !== {es[i], eo[i]}) begin
          bad++;
          $display("FAIL misaligned%0d cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                   j, i, state, strobes(), es[i], eo[i]);
        end
        @(negedge clock);
      end
      #1;
      total++;
      if ({fault, halted} !== 2'b10) begin
        bad++;
        $display("FAIL misaligned%0d_sticky got fault=%b halted=%b want fault=1 halted=0",
                 j, fault, halted);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_fetch_timeout();
    // 16 stalled FETCH cycles: the 16th sees the counter at 15 and faults.
    apply_reset();
    mem_ready = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, MEM_WORD, 2'd0);
    for (int i = 0; i < 16; i++) begin
      #1;
      total++;
      if ({state, strobes()} !== {FETCH, S_WAIT}) begin
        bad++;
        $display("FAIL timeout cyc%0d got state=%0d strobes=%b want state=0 strobes=%b",
                 i, state, strobes(), S_WAIT);
      end
      @(negedge clock);
    end
    #1;
    total++;
    if ({state, fault} !== {FAULT, 1'b1}) begin
      bad++;
      $display("FAIL timeout_fault got state=%0d fault=%b want state=7 fault=1", state, fault);
    end
    @(negedge clock);
    // mem_ready arriving on the expiry cycle wins.
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i == 15);
      @(negedge clock);
      if (i == 14) begin
        mem_ready = 1'b1;
        #1;
        total++;
        if ({state, strobes()} !== {FETCH, S_FETCH}) begin
          bad++;
          $display("FAIL expiry_ready got state=%0d strobes=%b want state=0 strobes=%b",
                   state, strobes(), S_FETCH);
        end
        @(negedge clock);
        break;
      end
    end
    #1;
    total++;
    if ({state, fault} !== {DECODE, 1'b0}) begin
      bad++;
      $display("FAIL expiry_decode got state=%0d fault=%b want state=1 fault=0", state, fault);
    end
    @(negedge clock);
  endtask

  // Halt has priority over a simultaneous jump.
  task automatic test_halt();
    logic [2:0] es [0:4];
    logic [7:0] eo [0:4];
    es = '{FETCH, DECODE, EXECUTE, HALTED, HALTED};
    eo = '{S_FETCH, S_NONE, S_NONE, S_NONE, S_NONE};
    apply_reset();
    mem_ready = 1'b1;
    set_instr(1'b0, 1'b0, 1'b1, 1'b1, MEM_WORD, 2'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({state, strobes()} !== {es[i], eo[i]}) begin
        bad++;
        $display("FAIL halt cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, state, strobes(), es[i], eo[i]);
      end
      @(negedge clock);
    end
    #1;
    total++;
    if ({halted, fault} !== 2'b10) begin
      bad++;
      $display("FAIL halt_sticky got halted=%b fault=%b want halted=1 fault=0", halted, fault);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_store();
    logic [2:0] es [0:4];
    logic [7:0] eo [0:4];
    logic       rd [0:4];
    es = '{FETCH, DECODE, EXECUTE, MEM_ADDR, MEM_ACCESS};
    eo = '{S_FETCH, S_NONE, S_NONE, S_ADDR, S_STORE};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    set_instr(1'b0, 1'b1, 1'b0, 1'b0, MEM_WORD, 2'd0);
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd[i];
      #1;
      total++;
      if ({state, strobes()} !== {es[i], eo[i]}) begin
        bad++;
        $display("FAIL mid_store cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, state, strobes(), es[i], eo[i]);
      end
      @(negedge clock);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({state, strobes()} !== {MEM_ACCESS, S_NONE}) begin
      bad++;
      $display("FAIL mid_store_reset got state=%0d strobes=%b want state=4 strobes=%b",
               state, strobes(), S_NONE);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if ({state, halted, fault} !== {FETCH, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_store_after got state=%0d halted=%b fault=%b want state=0 halted=0 fault=0",
               state, halted, fault);
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, MEM_WORD, 2'd0);
    @(negedge clock);
    test_reset();
    test_alu();
    test_jump();
    test_load_wait();
    test_store_byte();
    test_misaligned();
    test_fetch_timeout();
    test_halt();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle control FSM for the core; drives the program counter's write, jump, use_offset and address_in_to_AD controls, plus the memory strobes, IR load and register-file write.
- Sequences fetch, decode, execute, data address and data access, with a memory ready handshake and a bounded-wait timeout.
- Sits between the decoder/ALU and the program counter and memory interface; it is the only source of those control strobes.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles a memory access may wait for mem_ready before fault.
- TIMER_W, 4: width of the wait counter. Must satisfy 2**TIMER_W > MEM_TIMEOUT.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- mem_ready  in  1  memory completes the current access this cycle
- is_load  in  1  decoded instruction is a load; valid in EXECUTE
- is_store  in  1  decoded instruction is a store; valid in EXECUTE
- is_jump  in  1  JAL/JALR or taken branch; valid in EXECUTE
- is_halt  in  1  EBREAK/ECALL halt request; valid in EXECUTE
- mem_size  in  2  0 byte, 1 half, 2 word; 3 reserved, treated as word
- addr_low  in  2  ALU effective address bits [1:0]; valid in MEM_ADDR
- pc_write  out  1  advance PC (last<=current, current<=next, next+1)
- pc_jump  out  1  load PC next from address_in
- pc_use_offset  out  1  AD bus carries unaligned address
- pc_addr_to_ad  out  1  AD bus carries data address instead of PC next
- mem_read  out  1  read request
- mem_write  out  1  write request
- ir_load  out  1  latch instruction register
- reg_write  out  1  register-file write enable
- halted  out  1  sticky halt indicator
- fault  out  1  sticky fault indicator (misaligned access or timeout)
- state  out  3  current state encoding, for debug

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM_ADDR, MEM_ACCESS, WRITEBACK, HALTED, FAULT.
- Outputs are combinational from state and inputs.
- While reset is high, every strobe is 0.
- Reset:
  - state<=FETCH, timer<=0, halted=0, fault=0.
  - Applies from any state, including mid-access; no write strobe may be issued in the reset cycle.
- FETCH:
  - mem_read=1, pc_addr_to_ad=0.
  - On mem_ready: ir_load=1 and pc_write=1 in the same cycle, then go to DECODE.
  - Otherwise hold.
- DECODE: single cycle, no strobes; then go to EXECUTE.
- EXECUTE, priority halt > jump > memory > ALU:
  - is_halt: go to HALTED.
  - is_jump: pc_jump=1 and reg_write=1 (link uses PC current); go to FETCH.
  - is_load or is_store: go to MEM_ADDR.
  - Otherwise: reg_write=1; go to FETCH.
- MEM_ADDR:
  - pc_addr_to_ad=1, pc_use_offset=1; PC latches data_offset.
  - Misaligned when (half and addr_low[0]) or (word and addr_low != 0). Misaligned: go to FAULT with no strobe.
  - Aligned: go to MEM_ACCESS.
- MEM_ACCESS:
  - pc_addr_to_ad=1, pc_use_offset=1, mem_read=is_load, mem_write=is_store; decoder outputs are held stable by the IR.
  - On mem_ready: a load goes to WRITEBACK; a store goes to FETCH.
- WRITEBACK: reg_write=1 for one cycle; go to FETCH.
- Timer:
  - Cleared on entry to FETCH or MEM_ACCESS.
  - Increments each cycle in those states while mem_ready=0.
  - If timer==MEM_TIMEOUT with mem_ready=0, go to FAULT.
  - mem_ready in the same cycle as expiry wins; the access completes normally.
- HALTED and FAULT:
  - Absorbing, with all strobes 0; halted=1 or fault=1 respectively.
  - Exited only by reset.
- pc_jump and pc_write are never asserted in the same cycle.
- mem_read and mem_write are never asserted in the same cycle.
- Minimum latency: ALU instruction 3 cycles; load 6; store 5 (with mem_ready immediate).

Decomposition:
- Shared package cpu_pkg holds:
  - seq_state_t enum: FETCH=0, DECODE=1, EXECUTE=2, MEM_ADDR=3, MEM_ACCESS=4, WRITEBACK=5, HALTED=6, FAULT=7.
  - Constants MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2.
- One sub-module, access_timer, holds the clear/increment/expire counter parameterized by MEM_TIMEOUT and TIMER_W.
- The FSM stays in instruction_sequencer.

Test Plan:
- Reset, then ALU op with mem_ready tied 1 -> states FETCH, DECODE, EXECUTE; pc_write and ir_load in cycle 1, reg_write in cycle 3; PC current goes 0 then 4.
- is_jump in EXECUTE -> pc_jump=1 and reg_write=1 for exactly one cycle; next FETCH drives AD from the new next; pc_write never coincides with pc_jump.
- Word load, addr_low=0, mem_ready delayed 3 cycles -> mem_read held 4 cycles with pc_addr_to_ad=1; WRITEBACK reg_write=1; back to FETCH.
- Half store with addr_low=1 -> FAULT after MEM_ADDR; mem_write never asserted; fault=1 persists until reset.
- FETCH with mem_ready=0 for 16 cycles (MEM_TIMEOUT=15) -> FAULT. Repeat with mem_ready arriving on the expiry cycle -> no fault; DECODE next.
- Reset asserted mid MEM_ACCESS of a store -> mem_write=0 in the reset cycle; state=FETCH afterwards; halted=0, fault=0.
